// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the two-port on-chip RAM arbiter: port indices,
// default bus widths and the per-port request bundle.
package onchip_mem_pkg;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    // Width of the hold counter; MAX_HOLD must fit (1..15).
    localparam int HOLD_W = 4;

    // One Avalon-MM slave port's request fields, sized by the defaults above.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_BE_W-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [DEF_DATA_W-1:0] writedata;
    } mem_req_t;

endpackage

// File: rtl/onchip_mem_rr_grant.sv
// Two-way round-robin grant with a bounded hold. The current owner keeps
// the RAM under contention until it has taken MAX_HOLD+1 accepts in a row,
// then the grant moves to the other port.
module onchip_mem_rr_grant
    import onchip_mem_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last_owner
);

    logic [HOLD_W-1:0] hold_cnt;
    // Cleared by reset: until the first accept, the reset owner (port 1) is
    // treated as having used up its hold, so port 0 wins the first contention.
    logic              owned;
    logic              keep_owner;
    logic              contend_port;
    logic              acc_port;
    logic              other_req;

    // Grant decision from the live requests and the registered arbitration state.
    always_comb begin
        keep_owner   = owned && (hold_cnt < HOLD_W'(MAX_HOLD));
        contend_port = keep_owner ? last_owner : ~last_owner;
        grant        = 2'b00;
        if (ready) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = contend_port ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign acc_port  = grant[1];
    assign other_req = acc_port ? req[0] : req[1];

    // Track the owner and how long it has held the RAM against a waiting peer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            owned      <= 1'b0;
        end else if (accept) begin
            owned      <= 1'b1;
            last_owner <= acc_port;
            if ((acc_port == last_owner) && other_req) begin
                if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbiter sharing the 32K x 32 single-port on-chip RAM between the Nios II
// data master (s0) and the DMA/packet engine (s1).
//
// Handshake: a port's transfer is accepted in any cycle where its read or
// write is high and its waitrequest is low; while waitrequest is high the
// master holds every request field stable. Reads return exactly one cycle
// after acceptance on the shared readdata bus, qualified by that port's
// readdatavalid. Writes complete on acceptance with no response. A request
// with both read and write high is a write.
//
// Port widths must match the package defaults; the request bundle is sized
// from them.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    mem_req_t   port_req [2];
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] acc;
    logic [1:0] rd_acc;
    logic [1:0] rd_pend;
    logic       accept;
    logic       ready;
    logic       last_owner;
    logic       sel;

    // Bundle each port's request fields.
    always_comb begin
        port_req[PORT0].address    = s0_address;
        port_req[PORT0].byteenable = s0_byteenable;
        port_req[PORT0].read       = s0_read;
        port_req[PORT0].write      = s0_write;
        port_req[PORT0].writedata  = s0_writedata;
        port_req[PORT1].address    = s1_address;
        port_req[PORT1].byteenable = s1_byteenable;
        port_req[PORT1].read       = s1_read;
        port_req[PORT1].write      = s1_write;
        port_req[PORT1].writedata  = s1_writedata;
    end

    assign req[PORT0] = port_req[PORT0].read | port_req[PORT0].write;
    assign req[PORT1] = port_req[PORT1].read | port_req[PORT1].write;

    onchip_mem_rr_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr_grant (
        .clk        (clk),
        .reset_n    (reset_n),
        .ready      (ready),
        .req        (req),
        .accept     (accept),
        .grant      (grant),
        .last_owner (last_owner)
    );

    assign acc    = req & grant;
    assign accept = |acc;

    // Only a pure read produces a return; read+write is a write.
    assign rd_acc[PORT0] = acc[PORT0] & port_req[PORT0].read & ~port_req[PORT0].write;
    assign rd_acc[PORT1] = acc[PORT1] & port_req[PORT1].read & ~port_req[PORT1].write;

    assign s0_waitrequest = req[PORT0] & ~grant[PORT0];
    assign s1_waitrequest = req[PORT1] & ~grant[PORT1];

    // When idle the mux stays on the most recent owner.
    assign sel = grant[PORT1] ? 1'b1 : (grant[PORT0] ? 1'b0 : last_owner);

    assign mem_address    = sel ? port_req[PORT1].address    : port_req[PORT0].address;
    assign mem_byteenable = sel ? port_req[PORT1].byteenable : port_req[PORT0].byteenable;
    assign mem_writedata  = sel ? port_req[PORT1].writedata  : port_req[PORT0].writedata;
    assign mem_chipselect = accept;
    assign mem_write      = accept & (sel ? port_req[PORT1].write : port_req[PORT0].write);
    assign mem_clken      = ready;

    // ready holds the RAM and both ports off for the first cycle after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    // One-cycle read return tracker; reset drops any return in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= rd_acc;
        end
    end

    assign s0_readdatavalid = rd_pend[PORT0];
    assign s1_readdatavalid = rd_pend[PORT1];
    assign s0_readdata      = mem_readdata;
    assign s1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, directed sequences, a vector
// table of single-port transactions and a randomized run against a
// run-length reference model of the arbitration policy.
module tb_onchip_mem_arbiter;

    localparam int MAX_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] s0_address, s1_address, mem_address;
    logic [3:0]  s0_byteenable, s1_byteenable, mem_byteenable;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [31:0] s0_writedata, s1_writedata, mem_writedata;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata, mem_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    onchip_mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s0_address       (s0_address),
        .s0_byteenable    (s0_byteenable),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_writedata     (s0_writedata),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_byteenable    (s1_byteenable),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // ---------------- RAM model (registered address, q next cycle) ----------------
    logic [31:0] ram    [0:32767];
    logic [31:0] shadow [0:32767];

    function automatic logic [31:0] init_word(input int a);
        return {16'hA5C3, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int          exp_port_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic wait_of(input int p);
        return (p == 0) ? s0_waitrequest : s1_waitrequest;
    endfunction
    function automatic logic valid_of(input int p);
        return (p == 0) ? s0_readdatavalid : s1_readdatavalid;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? s0_readdata : s1_readdata;
    endfunction

    // Compare this cycle's read returns against the expected queue.
    task automatic check_returns(input string tag);
        int          ep;
        logic [31:0] ed;
        if (exp_port_q.size() > 0) begin
            ep = exp_port_q.pop_front();
            ed = exp_q.pop_front();
            check_bit({tag, " valid own"}, valid_of(ep), 1'b1);
            check({tag, " readdata"}, rdata_of(ep), ed);
            check_bit({tag, " valid other"}, valid_of(1 - ep), 1'b0);
        end else begin
            check_bit({tag, " s0 valid idle"}, s0_readdatavalid, 1'b0);
            check_bit({tag, " s1 valid idle"}, s1_readdatavalid, 1'b0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic rd, input logic wr, input logic [14:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = d;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
        end
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    endtask

    typedef struct {
        string       name;
        int          port;
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    // One single-port transfer; entered and left just after a rising edge.
    task automatic do_txn(input vec_t v);
        int n;
        set_port(v.port, v.rd, v.wr, v.addr, v.be, v.wdata);
        n = 0;
        @(negedge clk);
        while (wait_of(v.port) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_bit({v.name, " accepted"}, wait_of(v.port), 1'b0);
        check_bit({v.name, " mem_write"}, mem_write, v.wr);
        check({v.name, " mem_address"}, 32'(mem_address), 32'(v.addr));
        @(posedge clk); #1;
        set_port(v.port, 1'b0, 1'b0, v.addr, 4'h0, 32'h0);
        @(negedge clk);
        check_bit({v.name, " readdatavalid"}, valid_of(v.port), v.chk);
        if (v.chk) check({v.name, " readdata"}, rdata_of(v.port), v.exp);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        idle_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("pulse reset chipselect", mem_chipselect, 1'b0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- reference arbitration model ----------------
    // Owner run length: the owner keeps a contended RAM for MAX_HOLD+1
    // consecutive accepts; a run restarts when the peer was not waiting.
    int m_owner;
    int m_run;

    function automatic int model_pick(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (m_owner < 0) return 0;
        return (m_run < MAX_HOLD + 1) ? m_owner : 1 - m_owner;
    endfunction

    task automatic model_accept(input int g, input bit other_waiting);
        if (g == m_owner && other_waiting) m_run++;
        else m_run = 1;
        m_owner = g;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    bit          pend  [2];
    logic        prd   [2];
    logic        pwr   [2];
    logic [14:0] pa    [2];
    logic [3:0]  pbe   [2];
    logic [31:0] pd    [2];
    int          g;
    int          r;

    initial begin
        vecs[0] = '{"wr_full_0200", 0, 1'b0, 1'b1, 15'h0200, 4'hF, 32'h11223344, 1'b0, 32'h0};
        vecs[1] = '{"wr_be2_0200",  1, 1'b0, 1'b1, 15'h0200, 4'h2, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[2] = '{"rd_0200",      0, 1'b1, 1'b0, 15'h0200, 4'hF, 32'h0,        1'b1, 32'h1122CC44};
        vecs[3] = '{"rdwr_0001",    0, 1'b1, 1'b1, 15'h0001, 4'hF, 32'h00000055, 1'b0, 32'h0};
        vecs[4] = '{"rd_0001",      1, 1'b1, 1'b0, 15'h0001, 4'hF, 32'h0,        1'b1, 32'h00000055};
        vecs[5] = '{"wr_full_0003", 1, 1'b0, 1'b1, 15'h0003, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[6] = '{"wr_be9_0003",  0, 1'b0, 1'b1, 15'h0003, 4'h9, 32'h12345678, 1'b0, 32'h0};
        vecs[7] = '{"rd_0003",      1, 1'b1, 1'b0, 15'h0003, 4'hF, 32'h0,        1'b1, 32'h12FFFF78};
        vecs[8] = '{"rd_7fff",      0, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0,        1'b1, 32'h12345678};

        for (int i = 0; i < 32768; i++) begin
            ram[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        ram[16] = 32'hDEADBEEF;

        // Reset, then first read of 0x0010 waits for ready.
        reset_n = 1'b0;
        idle_all();
        set_port(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check_bit("reset s0_waitrequest", s0_waitrequest, 1'b1);
        check_bit("reset chipselect", mem_chipselect, 1'b0);
        check_bit("reset clken", mem_clken, 1'b0);
        check_bit("reset s0 valid", s0_readdatavalid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("not-ready s0_waitrequest", s0_waitrequest, 1'b1);
        check_bit("not-ready chipselect", mem_chipselect, 1'b0);
        check_bit("not-ready clken", mem_clken, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("first read accepted", s0_waitrequest, 1'b0);
        check_bit("first read chipselect", mem_chipselect, 1'b1);
        check_bit("ready clken", mem_clken, 1'b1);
        check("first read address", 32'(mem_address), 32'h0010);
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
        check_bit("first read s0 valid", s0_readdatavalid, 1'b1);
        check("first read data", s0_readdata, 32'hDEADBEEF);
        check_bit("first read s1 valid", s1_readdatavalid, 1'b0);
        @(posedge clk); #1;

        // Simultaneous s0 write / s1 read of the top address.
        set_port(0, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'h12345678);
        set_port(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0);
        @(negedge clk);
        check_bit("wr/rd s0 granted", s0_waitrequest, 1'b0);
        check_bit("wr/rd s1 stalled", s1_waitrequest, 1'b1);
        check_bit("wr/rd mem_write", mem_write, 1'b1);
        check("wr/rd address", 32'(mem_address), 32'h7FFF);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        @(negedge clk);
        check_bit("wr/rd s1 granted", s1_waitrequest, 1'b0);
        check_bit("wr/rd read no write", mem_write, 1'b0);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        @(negedge clk);
        check_bit("wr/rd s1 valid", s1_readdatavalid, 1'b1);
        check("wr/rd s1 data", s1_readdata, 32'h12345678);
        check_bit("wr/rd s0 valid", s0_readdatavalid, 1'b0);
        @(posedge clk); #1;

        // Vector table of single-port transfers.
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Reset in the cycle after an s1 read is accepted.
        set_port(1, 1'b1, 1'b0, 15'h0001, 4'hF, 32'h0);
        @(negedge clk);
        check_bit("mid-read s1 accepted", s1_waitrequest, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 15'h4000, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 15'h4001, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("mid-read s1 valid dropped", s1_readdatavalid, 1'b0);
            check_bit("mid-read s0 valid", s0_readdatavalid, 1'b0);
            check_bit("mid-read chipselect", mem_chipselect, 1'b0);
            check_bit("mid-read s0 waitrequest", s0_waitrequest, 1'b1);
            check_bit("mid-read s1 waitrequest", s1_waitrequest, 1'b1);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("release chipselect", mem_chipselect, 1'b0);
        check_bit("release s1 valid", s1_readdatavalid, 1'b0);
        check_bit("release clken", mem_clken, 1'b0);
        @(posedge clk); #1;

        // Both stream reads: s0 x5, s1 x5, ... with s0 winning first.
        exp_q.delete();
        exp_port_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_returns("stream");
            g = (c / 5) % 2;
            check_bit($sformatf("stream c%0d s0_waitrequest", c), s0_waitrequest, g != 0);
            check_bit($sformatf("stream c%0d s1_waitrequest", c), s1_waitrequest, g != 1);
            exp_q.push_back(init_word(g == 0 ? 32'h4000 : 32'h4001));
            exp_port_q.push_back(g);
            @(posedge clk); #1;
        end
        idle_all();
        @(negedge clk);
        check_returns("stream tail");
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        pulse_reset();
        m_owner = -1;
        m_run   = 0;
        exp_q.delete();
        exp_port_q.delete();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    r      = $urandom_range(0, 9);
                    prd[p] = (r <= 3) || (r == 7);
                    pwr[p] = (r >= 4) && (r <= 7);
                    pa[p]  = 15'h4000 + 15'($urandom_range(0, 15));
                    pbe[p] = 4'($urandom_range(1, 15));
                    pd[p]  = $urandom();
                    set_port(p, prd[p], pwr[p], pa[p], pbe[p], pd[p]);
                    pend[p] = prd[p] | pwr[p];
                end
            end
            @(negedge clk);
            check_returns("rnd");
            g = model_pick(pend[0], pend[1]);
            check_bit("rnd s0_waitrequest", s0_waitrequest, pend[0] && (g != 0));
            check_bit("rnd s1_waitrequest", s1_waitrequest, pend[1] && (g != 1));
            check_bit("rnd chipselect", mem_chipselect, g >= 0);
            if (g >= 0) begin
                check_bit("rnd mem_write", mem_write, pwr[g]);
                check("rnd mem_address", 32'(mem_address), 32'(pa[g]));
                if (pwr[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (pbe[g][b]) shadow[pa[g]][8*b +: 8] = pd[g][8*b +: 8];
                end else begin
                    exp_q.push_back(shadow[pa[g]]);
                    exp_port_q.push_back(g);
                end
                model_accept(g, pend[1 - g]);
                pend[g] = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_all();
        @(negedge clk);
        check_returns("rnd tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
